jt1943_rom_arbiter: RTL and testbench

- Shares the single SDRAM read port between the game's ROM requesters: main CPU, sound CPU, char, scroll and object.
- Sits between the game ROM clients and the SDRAM controller.
- Sequences reads, refresh and the ROM-download lockout.
- Round-robin arbitration with a one-entry, 32-bit data cache per slot, so repeated reads of the same address complete without SDRAM traffic.

---
 rtl/jt1943_rom_pkg.sv | 25 ++
 rtl/jt1943_rr_pick.sv | 27 ++
 rtl/jt1943_rom_arbiter.sv | 130 +++++++++++++
 tb/tb_jt1943_rom_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_rom_pkg.sv
// Shared types and constants for the 1943 ROM arbiter: FSM states, slot
// indices and default SDRAM widths.
package jt1943_rom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAIN = 0;
    localparam int SND  = 1;
    localparam int CHAR = 2;
    localparam int SCR  = 3;
    localparam int OBJ  = 4;

    localparam int ROM_AW = 22;
    localparam int ROM_DW = 32;

    // Index width that stays legal for a single-slot build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jt1943_rr_pick.sv
// Combinational round-robin picker: first set bit of pend scanning upward
// from rr, wrapping modulo N.
module jt1943_rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
)(
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] rr,
    output logic [IW-1:0] idx,
    output logic          any
);

    int c;

    // Scan from farthest to nearest so the slot closest to rr wins.
    always_comb begin
        idx = '0;
        c   = 0;
        any = |pend;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(rr) + k;
            if (c >= N) c = c - N;
            if (pend[c]) idx = IW'(c);
        end
    end

endmodule

// File: rtl/jt1943_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among the ROM clients,
// with a one-entry data cache per slot, refresh insertion and download lockout.
module jt1943_rom_arbiter
    import jt1943_rom_pkg::*;
#(
    parameter int NSLOT = 5,
    parameter int AW    = ROM_AW,
    parameter int DW    = ROM_DW
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [NSLOT-1:0]    slot_cs,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [NSLOT*DW-1:0] slot_dout,
    input  logic               refresh_req,
    output logic               sdram_req,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_rdy,
    input  logic [DW-1:0]      sdram_data,
    output logic               autorefresh,
    output logic               busy
);

    localparam int IW = idx_w(NSLOT);
    localparam logic [IW-1:0] LAST = IW'(NSLOT - 1);

    state_t state, state_nx;

    logic [NSLOT-1:0][AW-1:0] addr_in, last_addr;
    logic [NSLOT-1:0][DW-1:0] dout;
    logic [NSLOT-1:0]         valid, hit, pend;
    logic [IW-1:0]            rr, cur, pick_idx;
    logic                     pick_any, ref_pend;
    logic                     do_ref, do_read, do_fill, clr_valid, rdy_done;

    assign addr_in   = slot_addr;
    assign slot_dout = dout;
    assign busy      = (state != IDLE);

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        assign hit[i]     = valid[i] & (addr_in[i] == last_addr[i]);
        assign slot_ok[i] = slot_cs[i] & hit[i];
        assign pend[i]    = slot_cs[i] & ~hit[i] & ~downloading;
    end

    jt1943_rr_pick #(.N(NSLOT), .IW(IW)) u_pick (
        .pend (pend),
        .rr   (rr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!downloading && !ref_pend && pick_any) state_nx = READ;
            READ:    if (sdram_rdy) state_nx = IDLE;
                     else if (downloading) state_nx = DRAIN;
            DRAIN:   if (sdram_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Data is only kept if the slot still wants the address that was fetched.
    always_comb begin
        do_ref    = 1'b0;
        do_read   = 1'b0;
        do_fill   = 1'b0;
        clr_valid = 1'b0;
        rdy_done  = 1'b0;
        case (state)
            IDLE: begin
                if (downloading)   clr_valid = 1'b1;
                else if (ref_pend) do_ref    = 1'b1;
                else if (pick_any) do_read   = 1'b1;
            end
            READ: begin
                if (sdram_rdy) begin
                    rdy_done = 1'b1;
                    do_fill  = ~downloading & (addr_in[cur] == sdram_addr);
                end
            end
            DRAIN:   if (sdram_rdy) clr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sdram_req   <= 1'b0;
            autorefresh <= 1'b0;
            sdram_addr  <= '0;
            cur         <= '0;
            rr          <= '0;
            ref_pend    <= 1'b0;
        end else begin
            sdram_req   <= do_read;
            autorefresh <= do_ref;
            if (refresh_req) ref_pend <= 1'b1;
            else if (do_ref) ref_pend <= 1'b0;
            if (do_read) begin
                cur        <= pick_idx;
                sdram_addr <= addr_in[pick_idx];
            end
            if (rdy_done) rr <= (cur == LAST) ? '0 : cur + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            last_addr <= '0;
            dout      <= '0;
        end else if (clr_valid) begin
            valid <= '0;
        end else if (do_fill) begin
            valid[cur]     <= 1'b1;
            last_addr[cur] <= sdram_addr;
            dout[cur]      <= sdram_data;
        end
    end

endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Directed bench for jt1943_rom_arbiter: expected SDRAM strobes are queued by
// the stimulus and checked in order by a negedge monitor.
module tb_jt1943_rom_arbiter;
    import jt1943_rom_pkg::*;

    localparam int NS = 5;
    localparam int AW = ROM_AW;
    localparam int DW = ROM_DW;

    logic                 clk = 1'b0;
    logic                 rst_n, downloading, refresh_req, sdram_req, sdram_rdy;
    logic                 autorefresh, busy;
    logic [NS-1:0]        cs, slot_ok;
    logic [NS-1:0][AW-1:0] addr_v;
    logic [NS-1:0][DW-1:0] dout_v;
    logic [AW-1:0]        sdram_addr;
    logic [DW-1:0]        sdram_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          is_ref;
        logic [AW-1:0] addr;
    } ev_t;
    ev_t expq[$];

    always #5 clk = ~clk;

    jt1943_rom_arbiter #(.NSLOT(NS), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_cs     (cs),
        .slot_addr   (addr_v),
        .slot_ok     (slot_ok),
        .slot_dout   (dout_v),
        .refresh_req (refresh_req),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_rdy   (sdram_rdy),
        .sdram_data  (sdram_data),
        .autorefresh (autorefresh),
        .busy        (busy)
    );

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        logic [1:0] got, want;
        if (sdram_req || autorefresh) begin
            total++;
            got = {autorefresh, sdram_req};
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe ref/req=%b addr=%h want=none", got, sdram_addr);
            end else begin
                e = expq.pop_front();
                want = e.is_ref ? 2'b10 : 2'b01;
                if (got !== want || (!e.is_ref && sdram_addr !== e.addr)) begin
                    bad++;
                    $display("FAIL strobe_order ref/req=%b addr=%h want ref/req=%b addr=%h",
                             got, sdram_addr, want, e.addr);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [AW-1:0] a);
        ev_t e;
        e.is_ref = 1'b0;
        e.addr   = a;
        expq.push_back(e);
    endtask

    task automatic push_ref();
        ev_t e;
        e.is_ref = 1'b1;
        e.addr   = '0;
        expq.push_back(e);
    endtask

    // Returns at the negedge of the cycle in which sdram_req is high.
    task automatic wait_req(input string nm);
        int n = 0;
        @(negedge clk);
        while (!sdram_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!sdram_req) begin
            bad++;
            $display("FAIL %s timeout got=no_req want=req", nm);
        end
    endtask

    // rdy arrives k cycles after the req cycle; returns at the negedge after it.
    task automatic serve(input int k, input logic [DW-1:0] d);
        repeat (k) @(posedge clk);
        #1;
        sdram_rdy  = 1'b1;
        sdram_data = d;
        tick();
        sdram_rdy  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        cs    = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; downloading = 1'b0; refresh_req = 1'b0;
        sdram_rdy = 1'b0; sdram_data = '0; cs = '0; addr_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {63'd0, sdram_req}, 64'd0);
        chk("rst_ref",   {63'd0, autorefresh}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_addr",  64'(sdram_addr), 64'd0);
        chk("rst_dout",  {63'd0, |dout_v}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Single miss, then a zero-latency hit.
        tick();
        cs[CHAR] = 1'b1; addr_v[CHAR] = 22'h01234;
        push_req(22'h01234);
        @(negedge clk);
        chk("miss_no_req_yet", {63'd0, sdram_req}, 64'd0);
        @(negedge clk);
        chk("miss_req", {63'd0, sdram_req}, 64'd1);
        chk("miss_addr", 64'(sdram_addr), 64'h01234);
        chk("miss_ok_low", 64'(slot_ok), 64'd0);
        serve(6, 32'hDEADBEEF);
        chk("miss_ok", 64'(slot_ok), 64'b00100);
        chk("miss_dout", 64'(dout_v[CHAR]), 64'hDEADBEEF);
        tick(); cs[CHAR] = 1'b0;
        @(negedge clk);
        chk("cs_drop_ok", 64'(slot_ok), 64'd0);
        tick(); cs[CHAR] = 1'b1;
        @(negedge clk);
        chk("hit_ok", 64'(slot_ok), 64'b00100);
        repeat (3) @(negedge clk);
        chk("hit_no_req", {63'd0, sdram_req}, 64'd0);

        // Round robin from pointer 0.
        do_reset();
        tick();
        cs = 5'b10011;
        addr_v[MAIN] = 22'h200; addr_v[SND] = 22'h300; addr_v[OBJ] = 22'h400;
        push_req(22'h200); push_req(22'h300); push_req(22'h400);
        wait_req("rr0"); serve(4, 32'hA0000000);
        wait_req("rr1"); serve(4, 32'hA1111111);
        wait_req("rr4"); serve(4, 32'hA4444444);
        chk("rr_all_ok", 64'(slot_ok), 64'b10011);
        chk("rr_dout0", 64'(dout_v[MAIN]), 64'hA0000000);
        chk("rr_dout4", 64'(dout_v[OBJ]), 64'hA4444444);
        // Slot 1 moves first; slot 0 moves during that read and is reached by wrap.
        tick(); addr_v[SND] = 22'h304; push_req(22'h304);
        wait_req("rr1b");
        tick(); addr_v[MAIN] = 22'h204; push_req(22'h204);
        serve(4, 32'hB1111111);
        wait_req("rr0b"); serve(4, 32'hB0000000);
        chk("rr2_ok", 64'(slot_ok), 64'b10011);
        chk("rr2_dout1", 64'(dout_v[SND]), 64'hB1111111);
        chk("rr2_dout0", 64'(dout_v[MAIN]), 64'hB0000000);

        // Refresh requested mid-read waits for IDLE, then precedes slot 3.
        tick(); cs = 5'b00100; addr_v[CHAR] = 22'h500; push_req(22'h500);
        wait_req("ref_rd");
        tick(); refresh_req = 1'b1; cs[SCR] = 1'b1; addr_v[SCR] = 22'h600;
        push_ref(); push_req(22'h600);
        tick(); refresh_req = 1'b0;
        @(negedge clk);
        chk("ref_hold", {63'd0, autorefresh}, 64'd0);
        chk("ref_busy", {63'd0, busy}, 64'd1);
        serve(3, 32'h55555555);
        chk("ref_idle_gap", {63'd0, autorefresh}, 64'd0);
        chk("ref_slot2_ok", 64'(slot_ok[CHAR]), 64'd1);
        @(negedge clk);
        chk("ref_pulse", {62'd0, autorefresh, sdram_req}, 64'b10);
        @(negedge clk);
        chk("ref_then_req", {62'd0, autorefresh, sdram_req}, 64'b01);
        chk("ref_req_addr", 64'(sdram_addr), 64'h600);
        serve(4, 32'h66666666);
        chk("ref_slot3_dout", 64'(dout_v[SCR]), 64'h66666666);

        // Address changes while its read is outstanding.
        tick(); cs = 5'b00001; addr_v[MAIN] = 22'h100; push_req(22'h100);
        wait_req("stale_a");
        tick(); addr_v[MAIN] = 22'h104; push_req(22'h104);
        serve(4, 32'h11111111);
        chk("stale_ok_low", 64'(slot_ok[MAIN]), 64'd0);
        chk("stale_dout_kept", 64'(dout_v[MAIN]), 64'hB0000000);
        wait_req("stale_b"); serve(4, 32'h22222222);
        chk("stale_ok", 64'(slot_ok[MAIN]), 64'd1);
        chk("stale_dout", 64'(dout_v[MAIN]), 64'h22222222);

        // Download rising mid-read drains and flushes the cache.
        tick(); cs = 5'b00010; addr_v[SND] = 22'h700; push_req(22'h700);
        wait_req("dl_fill"); serve(4, 32'h77777777);
        chk("dl_prefill_ok", 64'(slot_ok[SND]), 64'd1);
        tick(); addr_v[SND] = 22'h704; push_req(22'h704);
        wait_req("dl_rd");
        tick(); downloading = 1'b1;
        @(negedge clk);
        chk("dl_busy_rd", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("dl_busy_drain", {63'd0, busy}, 64'd1);
        serve(2, 32'h12345678);
        chk("dl_idle", {63'd0, busy}, 64'd0);
        chk("dl_ok_low", 64'(slot_ok), 64'd0);
        tick(); addr_v[SND] = 22'h700;
        @(negedge clk);
        chk("dl_flushed", 64'(slot_ok[SND]), 64'd0);
        repeat (5) @(negedge clk);
        chk("dl_no_req", {63'd0, sdram_req}, 64'd0);
        tick(); push_req(22'h700); downloading = 1'b0;
        wait_req("dl_remiss"); serve(4, 32'h70707070);
        chk("dl_refill_ok", 64'(slot_ok[SND]), 64'd1);
        chk("dl_refill_dout", 64'(dout_v[SND]), 64'h70707070);

        // Reset during a read; the late rdy must not fill anything.
        tick(); cs = 5'b10000; addr_v[OBJ] = 22'h800; push_req(22'h800);
        wait_req("rst_rd");
        tick(); rst_n = 1'b0; cs = '0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {61'd0, sdram_req, autorefresh, busy}, 64'd0);
        chk("mid_rst_addr", 64'(sdram_addr), 64'd0);
        chk("mid_rst_dout", {63'd0, |dout_v}, 64'd0);
        tick(); sdram_rdy = 1'b1; sdram_data = 32'hBAD0BAD0;
        tick(); sdram_rdy = 1'b0;
        @(negedge clk);
        chk("late_rdy_busy", {63'd0, busy}, 64'd0);
        chk("late_rdy_dout", {63'd0, |dout_v}, 64'd0);
        tick(); push_req(22'h800); cs[OBJ] = 1'b1;
        @(negedge clk);
        chk("late_rdy_ok", 64'(slot_ok), 64'd0);
        wait_req("rst_remiss"); serve(4, 32'h88888888);
        chk("rst_refill_ok", 64'(slot_ok[OBJ]), 64'd1);

        repeat (5) tick();
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
